// File: rtl/pb_axi_err_responder_pkg.sv
// Shared types and constants for the AXI DECERR terminal responder.
package pb_axi_err_responder_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t AxiRespOkay   = 2'b00;
  localparam axi_resp_t AxiRespDecerr = 2'b11;

  localparam logic [31:0] DefaultRespPattern = 32'hBADCAB1E;

  localparam int unsigned AxiLenWidth  = 8;
  localparam int unsigned AxiAtopWidth = 6;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } pb_err_wstate_e;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_BURST = 1'b1
  } pb_err_rstate_e;

endpackage

// File: rtl/pb_axi_err_responder_if.sv
// AXI4+ATOP subset seen by the error responder (payload data/strobes never consumed).
interface pb_axi_err_responder_if
  import pb_axi_err_responder_pkg::*;
#(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned DataWidth = 64,
  parameter int unsigned IdWidth   = 4
) ();

  logic                    aw_valid;
  logic                    aw_ready;
  logic [IdWidth-1:0]      aw_id;
  logic [AddrWidth-1:0]    aw_addr;
  logic [AxiLenWidth-1:0]  aw_len;
  logic [AxiAtopWidth-1:0] aw_atop;

  logic                    w_valid;
  logic                    w_ready;
  logic                    w_last;

  logic                    b_valid;
  logic                    b_ready;
  logic [IdWidth-1:0]      b_id;
  axi_resp_t               b_resp;

  logic                    ar_valid;
  logic                    ar_ready;
  logic [IdWidth-1:0]      ar_id;
  logic [AddrWidth-1:0]    ar_addr;
  logic [AxiLenWidth-1:0]  ar_len;

  logic                    r_valid;
  logic                    r_ready;
  logic [IdWidth-1:0]      r_id;
  logic [DataWidth-1:0]    r_data;
  axi_resp_t               r_resp;
  logic                    r_last;

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_atop, w_valid, w_last, b_ready,
           ar_valid, ar_id, ar_addr, ar_len, r_ready,
    output aw_ready, w_ready, b_valid, b_id, b_resp, ar_ready,
           r_valid, r_id, r_data, r_resp, r_last
  );

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_atop, w_valid, w_last, b_ready,
           ar_valid, ar_id, ar_addr, ar_len, r_ready,
    input  aw_ready, w_ready, b_valid, b_id, b_resp, ar_ready,
           r_valid, r_id, r_data, r_resp, r_last
  );

endinterface

// File: rtl/pb_err_logger.sv
// Saturating count of rejected requests plus capture of the first offending address.
module pb_err_logger #(
  parameter int unsigned AddrWidth = 48,
  parameter int unsigned CntWidth  = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 aw_event,
  input  logic                 ar_event,
  input  logic [AddrWidth-1:0] aw_addr,
  input  logic [AddrWidth-1:0] ar_addr,
  output logic                 err_valid,
  output logic                 err_is_write,
  output logic [AddrWidth-1:0] err_addr,
  output logic [CntWidth-1:0]  err_cnt
);

  localparam int unsigned SumWidth = CntWidth + 1;

  logic [SumWidth-1:0] sum;

  // One extra bit catches overflow of a +1 or +2 step.
  assign sum = SumWidth'(err_cnt) + SumWidth'(aw_event) + SumWidth'(ar_event);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_valid    <= 1'b0;
      err_is_write <= 1'b0;
      err_addr     <= '0;
      err_cnt      <= '0;
    end else if (clr) begin
      err_valid <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_cnt <= sum[CntWidth] ? '1 : sum[CntWidth-1:0];
      // Write side wins when both channels fire together.
      if (!err_valid && (aw_event || ar_event)) begin
        err_valid    <= 1'b1;
        err_is_write <= aw_event;
        err_addr     <= aw_event ? aw_addr : ar_addr;
      end
    end
  end

endmodule

// File: rtl/pb_axi_err_responder.sv
// AXI4+ATOP terminal slave: answers every request with DECERR, ID-correct and burst-complete.
module pb_axi_err_responder
  import pb_axi_err_responder_pkg::*;
#(
  parameter int unsigned AddrWidth   = 48,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned IdWidth     = 4,
  parameter logic [31:0] RespPattern = DefaultRespPattern,
  parameter int unsigned CntWidth    = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  pb_axi_err_responder_if.slave bus,
  input  logic                 err_clr_i,
  output logic                 err_valid_o,
  output logic                 err_is_write_o,
  output logic [AddrWidth-1:0] err_addr_o,
  output logic [CntWidth-1:0]  err_cnt_o
);

  localparam logic [DataWidth-1:0] RDataFill = {(DataWidth / 32){RespPattern}};

  pb_err_wstate_e         wstate, wstate_n;
  pb_err_rstate_e         rstate, rstate_n;
  logic [IdWidth-1:0]     w_id_n, r_id_n, atop_id, atop_id_n;
  logic [AxiLenWidth-1:0] r_len, r_len_n, r_cnt, r_cnt_n, atop_len, atop_len_n;
  logic                   atop_pend, atop_pend_n, atop_set, atop_take;
  logic                   aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic                   unused_atop;

  assign aw_hs = bus.aw_valid & bus.aw_ready;
  assign w_hs  = bus.w_valid  & bus.w_ready;
  assign b_hs  = bus.b_valid  & bus.b_ready;
  assign ar_hs = bus.ar_valid & bus.ar_ready;
  assign r_hs  = bus.r_valid  & bus.r_ready;

  // Only the "atomic with read response" bit matters; the rest of the opcode is ignored.
  assign unused_atop = ^bus.aw_atop[AxiAtopWidth-2:0];

  // An atomic write owes a read burst; it stays pending until the read side picks it up.
  assign atop_pend_n = atop_set | (atop_pend & ~atop_take);

  always_comb begin
    wstate_n   = wstate;
    w_id_n     = bus.b_id;
    atop_set   = 1'b0;
    atop_id_n  = atop_id;
    atop_len_n = atop_len;
    unique case (wstate)
      W_IDLE: if (aw_hs) begin
        wstate_n = W_DATA;
        w_id_n   = bus.aw_id;
        if (bus.aw_atop[AxiAtopWidth-1]) begin
          atop_set   = 1'b1;
          atop_id_n  = bus.aw_id;
          atop_len_n = bus.aw_len;
        end
      end
      W_DATA:  if (w_hs && bus.w_last) wstate_n = W_RESP;
      W_RESP:  if (b_hs) wstate_n = W_IDLE;
      default: wstate_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : w_fsm
    if (!rst_ni) begin
      wstate       <= W_IDLE;
      atop_pend    <= 1'b0;
      atop_id      <= '0;
      atop_len     <= '0;
      bus.aw_ready <= 1'b1;
      bus.w_ready  <= 1'b0;
      bus.b_valid  <= 1'b0;
      bus.b_id     <= '0;
      bus.b_resp   <= AxiRespOkay;
    end else begin
      wstate       <= wstate_n;
      atop_pend    <= atop_pend_n;
      atop_id      <= atop_id_n;
      atop_len     <= atop_len_n;
      bus.aw_ready <= (wstate_n == W_IDLE) && !atop_pend_n;
      bus.w_ready  <= (wstate_n == W_DATA);
      bus.b_valid  <= (wstate_n == W_RESP);
      bus.b_id     <= w_id_n;
      bus.b_resp   <= (wstate_n == W_RESP) ? AxiRespDecerr : AxiRespOkay;
    end
  end

  // A pending atomic read response takes precedence over new AR requests.
  always_comb begin
    rstate_n  = rstate;
    r_id_n    = bus.r_id;
    r_len_n   = r_len;
    r_cnt_n   = r_cnt;
    atop_take = 1'b0;
    unique case (rstate)
      R_IDLE: if (atop_pend) begin
        rstate_n  = R_BURST;
        r_id_n    = atop_id;
        r_len_n   = atop_len;
        r_cnt_n   = '0;
        atop_take = 1'b1;
      end else if (ar_hs) begin
        rstate_n = R_BURST;
        r_id_n   = bus.ar_id;
        r_len_n  = bus.ar_len;
        r_cnt_n  = '0;
      end
      R_BURST: if (r_hs) begin
        r_cnt_n = AxiLenWidth'(r_cnt + AxiLenWidth'(1));
        if (bus.r_last) rstate_n = R_IDLE;
      end
      default: rstate_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin : r_fsm
    if (!rst_ni) begin
      rstate       <= R_IDLE;
      r_len        <= '0;
      r_cnt        <= '0;
      bus.ar_ready <= 1'b1;
      bus.r_valid  <= 1'b0;
      bus.r_id     <= '0;
      bus.r_data   <= '0;
      bus.r_resp   <= AxiRespOkay;
      bus.r_last   <= 1'b0;
    end else begin
      rstate       <= rstate_n;
      r_len        <= r_len_n;
      r_cnt        <= r_cnt_n;
      bus.ar_ready <= (rstate_n == R_IDLE) && !atop_pend_n;
      bus.r_valid  <= (rstate_n == R_BURST);
      bus.r_id     <= r_id_n;
      bus.r_data   <= (rstate_n == R_BURST) ? RDataFill : '0;
      bus.r_resp   <= (rstate_n == R_BURST) ? AxiRespDecerr : AxiRespOkay;
      bus.r_last   <= (rstate_n == R_BURST) && (r_cnt_n == r_len_n);
    end
  end

  pb_err_logger #(
    .AddrWidth (AddrWidth),
    .CntWidth  (CntWidth)
  ) i_logger (
    .clk          (clk_i),
    .rst_n        (rst_ni),
    .clr          (err_clr_i),
    .aw_event     (aw_hs),
    .ar_event     (ar_hs),
    .aw_addr      (bus.aw_addr),
    .ar_addr      (bus.ar_addr),
    .err_valid    (err_valid_o),
    .err_is_write (err_is_write_o),
    .err_addr     (err_addr_o),
    .err_cnt      (err_cnt_o)
  );

endmodule

// File: tb/tb_pb_axi_err_responder.sv
// Directed + randomized bench for pb_axi_err_responder against a transaction-level model.
module tb_pb_axi_err_responder;
  import pb_axi_err_responder_pkg::*;

  localparam int unsigned AW = 48;
  localparam int unsigned DW = 64;
  localparam int unsigned IW = 4;
  localparam int unsigned CW = 4;
  localparam int unsigned CNT_MAX = (1 << CW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          err_clr_i;
  logic          err_valid_o;
  logic          err_is_write_o;
  logic [AW-1:0] err_addr_o;
  logic [CW-1:0] err_cnt_o;

  pb_axi_err_responder_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) bus ();

  pb_axi_err_responder #(
    .AddrWidth (AW), .DataWidth (DW), .IdWidth (IW),
    .RespPattern (32'hBADCAB1E), .CntWidth (CW)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .bus            (bus),
    .err_clr_i      (err_clr_i),
    .err_valid_o    (err_valid_o),
    .err_is_write_o (err_is_write_o),
    .err_addr_o     (err_addr_o),
    .err_cnt_o      (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  // Reference model: expected log and counter from the request handshakes alone.
  int unsigned   m_cnt;
  bit            m_valid;
  bit            m_is_write;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] fill;

  function automatic void model_clear();
    m_cnt   = 0;
    m_valid = 1'b0;
  endfunction

  function automatic void model_event(input bit aw, input bit ar,
                                      input logic [AW-1:0] aw_a, input logic [AW-1:0] ar_a);
    if (!m_valid && (aw || ar)) begin
      m_valid    = 1'b1;
      m_is_write = aw;
      m_addr     = aw ? aw_a : ar_a;
    end
    m_cnt = m_cnt + int'(aw) + int'(ar);
    if (m_cnt > CNT_MAX) m_cnt = CNT_MAX;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_log();
    check("err_cnt", 64'(err_cnt_o), 64'(m_cnt));
    check("err_valid", 64'(err_valid_o), 64'(m_valid));
    if (m_valid) begin
      check("err_is_write", 64'(err_is_write_o), 64'(m_is_write));
      check("err_addr", 64'(err_addr_o), 64'(m_addr));
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len);
    bit ok = 1'b0;
    bus.ar_valid = 1'b1; bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = 8'(len);
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.ar_ready) begin
        ok = 1'b1;
        model_event(1'b0, 1'b1, '0, addr);
      end
      tick();
    end
    bus.ar_valid = 1'b0;
    check("ar_accept", 64'(ok), 64'd1);
  endtask

  task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr, input int len,
                         input logic [5:0] atop);
    bit ok = 1'b0;
    bus.aw_valid = 1'b1; bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = 8'(len);
    bus.aw_atop = atop;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (bus.aw_ready) begin
        ok = 1'b1;
        model_event(1'b1, 1'b0, addr, '0);
      end
      tick();
    end
    bus.aw_valid = 1'b0;
    bus.aw_atop  = '0;
    check("aw_accept", 64'(ok), 64'd1);
  endtask

  task automatic send_w(input int nbeats);
    for (int b = 0; b < nbeats; b++) begin
      bit ok = 1'b0;
      bus.w_valid = 1'b1;
      bus.w_last  = (b == nbeats - 1);
      for (int i = 0; i < 50 && !ok; i++) begin
        if (bus.w_ready) ok = 1'b1;
        tick();
      end
      check("w_accept", 64'(ok), 64'd1);
    end
    bus.w_valid = 1'b0;
    bus.w_last  = 1'b0;
  endtask

  task automatic recv_b(input logic [IW-1:0] id, input int stall);
    check("b_valid", 64'(bus.b_valid), 64'd1);
    check("b_id", 64'(bus.b_id), 64'(id));
    check("b_resp", 64'(bus.b_resp), 64'(2'b11));
    bus.b_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      tick();
      check("b_hold_valid", 64'(bus.b_valid), 64'd1);
      check("b_hold_id", 64'(bus.b_id), 64'(id));
      check("b_hold_resp", 64'(bus.b_resp), 64'(2'b11));
    end
    bus.b_ready = 1'b1;
    tick();
    bus.b_ready = 1'b0;
    check("b_done", 64'(bus.b_valid), 64'd0);
  endtask

  task automatic recv_r(input logic [IW-1:0] id, input int len, input bit stall);
    int k;
    for (int b = 0; b <= len; b++) begin
      if (stall) begin
        k = int'($urandom_range(0, 2));
        bus.r_ready = 1'b0;
        for (int s = 0; s < k; s++) begin
          tick();
          check("r_hold_valid", 64'(bus.r_valid), 64'd1);
          check("r_hold_last", 64'(bus.r_last), 64'(b == len));
        end
      end
      bus.r_ready = 1'b1;
      check("r_valid", 64'(bus.r_valid), 64'd1);
      check("r_id", 64'(bus.r_id), 64'(id));
      check("r_resp", 64'(bus.r_resp), 64'(2'b11));
      check("r_data", 64'(bus.r_data), 64'(fill));
      check("r_last", 64'(bus.r_last), 64'(b == len));
      tick();
    end
    bus.r_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    model_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IW-1:0] id, id2;
    logic [AW-1:0] a;
    int            len;

    for (int i = 0; i < int'(DW / 32); i++) fill[i*32 +: 32] = 32'hBADCAB1E;
    model_clear();
    err_clr_i = 1'b0;
    bus.aw_valid = 1'b0; bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_atop = '0;
    bus.w_valid = 1'b0; bus.w_last = 1'b0; bus.b_ready = 1'b0;
    bus.ar_valid = 1'b0; bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.r_ready = 1'b0;

    // Reset values
    repeat (3) tick();
    check("rst_aw_ready", 64'(bus.aw_ready), 64'd1);
    check("rst_ar_ready", 64'(bus.ar_ready), 64'd1);
    check("rst_w_ready", 64'(bus.w_ready), 64'd0);
    check("rst_b_valid", 64'(bus.b_valid), 64'd0);
    check("rst_r_valid", 64'(bus.r_valid), 64'd0);
    check("rst_r_data", 64'(bus.r_data), 64'd0);
    check_log();
    rst_ni = 1'b1;
    tick();

    // Read burst id=5 len=3, first beat the cycle after AR, ready again right after last
    a = rand_addr();
    send_ar(4'd5, a, 3);
    recv_r(4'd5, 3, 1'b0);
    check("r_idle_valid", 64'(bus.r_valid), 64'd0);
    check("r_next_ar_ready", 64'(bus.ar_ready), 64'd1);
    check_log();

    // W arrives before AW: held, then write id=2 len=0 with B back-pressured 5 cycles
    bus.w_valid = 1'b1; bus.w_last = 1'b1;
    tick(); tick();
    check("w_early_ready", 64'(bus.w_ready), 64'd0);
    check("w_early_b", 64'(bus.b_valid), 64'd0);
    send_aw(4'd2, rand_addr(), 0, 6'd0);
    send_w(1);
    recv_b(4'd2, 5);
    check("aw_ready_after_b", 64'(bus.aw_ready), 64'd1);
    check_log();

    // Simultaneous AW and AR: both accepted, write side logged
    pulse_clr();
    check_log();
    bus.aw_valid = 1'b1; bus.aw_id = 4'd1; bus.aw_addr = 48'h1000; bus.aw_len = 8'd0;
    bus.ar_valid = 1'b1; bus.ar_id = 4'd4; bus.ar_addr = 48'h2000; bus.ar_len = 8'd1;
    check("both_aw_ready", 64'(bus.aw_ready), 64'd1);
    check("both_ar_ready", 64'(bus.ar_ready), 64'd1);
    model_event(1'b1, 1'b1, 48'h1000, 48'h2000);
    tick();
    bus.aw_valid = 1'b0; bus.ar_valid = 1'b0;
    check_log();
    send_w(1);
    recv_b(4'd1, 0);
    recv_r(4'd4, 1, 1'b1);

    // Clear in the same cycle as an AR handshake: the event is dropped
    err_clr_i = 1'b1;
    bus.ar_valid = 1'b1; bus.ar_id = 4'd6; bus.ar_addr = rand_addr(); bus.ar_len = 8'd0;
    tick();
    err_clr_i = 1'b0; bus.ar_valid = 1'b0;
    model_clear();
    check_log();
    recv_r(4'd6, 0, 1'b0);

    // Atomic write while a read burst is still outstanding
    a = rand_addr();
    send_ar(4'd3, a, 7);
    send_aw(4'd7, rand_addr(), 1, 6'b110000);
    send_w(1);
    recv_b(4'd7, 1);
    check("atop_aw_block", 64'(bus.aw_ready), 64'd0);
    a = rand_addr();
    bus.aw_valid = 1'b1; bus.aw_id = 4'd9; bus.aw_addr = a; bus.aw_len = 8'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("atop_aw_stall", 64'(bus.aw_ready), 64'd0);
    end
    recv_r(4'd3, 7, 1'b0);
    check("atop_gap_valid", 64'(bus.r_valid), 64'd0);
    check("atop_gap_ar_ready", 64'(bus.ar_ready), 64'd0);
    check("atop_gap_aw_ready", 64'(bus.aw_ready), 64'd0);
    tick();
    check("atop_r_valid", 64'(bus.r_valid), 64'd1);
    check("atop_r_id0", 64'(bus.r_id), 64'd7);
    check("atop_r_last0", 64'(bus.r_last), 64'd0);
    check("atop_aw_release", 64'(bus.aw_ready), 64'd1);
    model_event(1'b1, 1'b0, a, '0);
    bus.r_ready = 1'b1;
    tick();
    bus.aw_valid = 1'b0;
    check("atop_r_id1", 64'(bus.r_id), 64'd7);
    check("atop_r_last1", 64'(bus.r_last), 64'd1);
    tick();
    bus.r_ready = 1'b0;
    check("atop_r_done", 64'(bus.r_valid), 64'd0);
    check("atop_ar_ready", 64'(bus.ar_ready), 64'd1);
    send_w(1);
    recv_b(4'd9, 0);
    check_log();

    // Reset in the middle of a len=7 read burst
    send_ar(4'd8, rand_addr(), 7);
    bus.r_ready = 1'b1;
    tick(); tick();
    rst_ni = 1'b0;
    #1;
    model_clear();
    check("rst_mid_r_valid", 64'(bus.r_valid), 64'd0);
    check_log();
    bus.r_ready = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
    check("rst_rel_ar_ready", 64'(bus.ar_ready), 64'd1);
    check("rst_rel_aw_ready", 64'(bus.aw_ready), 64'd1);
    check("rst_rel_r_valid", 64'(bus.r_valid), 64'd0);

    // Twenty reads saturate a 4-bit counter at 15; clear brings it back to zero
    for (int n = 0; n < 20; n++) begin
      id = 4'($urandom_range(0, 15));
      send_ar(id, rand_addr(), 0);
      recv_r(id, 0, 1'b0);
      check_log();
    end
    pulse_clr();
    check_log();

    // Randomized mix of reads, writes and clears
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 4))
        0, 1: begin
          id  = 4'($urandom_range(0, 15));
          len = int'($urandom_range(0, 7));
          send_ar(id, rand_addr(), len);
          recv_r(id, len, 1'($urandom_range(0, 1)));
          check("rnd_r_done", 64'(bus.r_valid), 64'd0);
          check("rnd_ar_ready", 64'(bus.ar_ready), 64'd1);
        end
        2, 3: begin
          id2 = 4'($urandom_range(0, 15));
          len = int'($urandom_range(0, 3));
          send_aw(id2, rand_addr(), len, 6'd0);
          send_w(len + 1);
          recv_b(id2, int'($urandom_range(0, 3)));
        end
        default: pulse_clr();
      endcase
      check_log();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
